// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
// Contents: sequencer state encoding (CSR-visible), state width, lock-loss
// counter width and its saturation value.
package pll_seq_pkg;

  localparam int unsigned STATE_W = 3;

  // Encodings are software-visible through state_o; do not renumber.
  typedef enum logic [STATE_W-1:0] {
    StAssertRst = 3'd0,
    StWaitLock  = 3'd1,
    StStable    = 3'd2,
    StRun       = 3'd3,
    StFail      = 3'd4
  } pll_state_e;

  localparam int unsigned               LOSS_CNT_W   = 8;
  localparam logic [LOSS_CNT_W-1:0]     LOSS_CNT_SAT = 8'hFF;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop single-bit synchronizer.
// Ports:
//   clk     - destination clock
//   reset_n - synchronous active-low reset, loads RESET_VAL into both flops
//   d       - asynchronous input
//   q       - synchronized output, two destination cycles of latency
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL power-up / recovery sequencer. Pulses the PLL reset, waits for lock,
// qualifies it over a contiguous window, then releases the system reset.
// A lock drop while running re-sequences; repeated lock timeouts end in a
// sticky failure that only reset_n or sw_reset_req clears.
// Ports:
//   clk           - reference clock (same net as PLL refclk)
//   reset_n       - synchronous active-low reset
//   pll_locked    - PLL lock indicator, asynchronous to clk
//   sw_reset_req  - one-cycle request to restart sequencing
//   pll_rst       - PLL reset, active high
//   sys_rst_n     - downstream reset, active low
//   fail          - sticky, all attempts exhausted
//   state_o       - current state encoding
//   retry_cnt     - failed attempts in the current sequence
//   lock_loss_cnt - saturating count of lock drops seen while running
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 17
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  sw_reset_req,
  output logic                  pll_rst,
  output logic                  sys_rst_n,
  output logic                  fail,
  output logic [STATE_W-1:0]    state_o,
  output logic [1:0]            retry_cnt,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       RETRY_LAST   = 2'(MAX_RETRIES);

  pll_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             lock_s;

  sync_2ff #(
    .RESET_VAL (1'b0)
  ) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (lock_s)
  );

  assign state_o = state;

  // Outputs are written alongside every state change so they always reflect
  // the state being entered; states with no transition leave them untouched.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= StAssertRst;
      cnt           <= '0;
      pll_rst       <= 1'b1;
      sys_rst_n     <= 1'b0;
      fail          <= 1'b0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
    end else if (sw_reset_req) begin
      state     <= StAssertRst;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
    end else begin
      case (state)
        StAssertRst: begin
          if (cnt == PULSE_LAST) begin
            state   <= StWaitLock;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StWaitLock: begin
          if (lock_s) begin
            state <= StStable;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt <= '0;
            if (retry_cnt == RETRY_LAST) begin
              state <= StFail;
              fail  <= 1'b1;
            end else begin
              state     <= StAssertRst;
              retry_cnt <= retry_cnt + 1'b1;
              pll_rst   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StStable: begin
          // Any dropout restarts the lock wait with a fresh timeout.
          if (!lock_s) begin
            state <= StWaitLock;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state     <= StRun;
            cnt       <= '0;
            sys_rst_n <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StRun: begin
          if (!lock_s) begin
            state     <= StAssertRst;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            retry_cnt <= '0;
            if (lock_loss_cnt != LOSS_CNT_SAT) begin
              lock_loss_cnt <= lock_loss_cnt + 1'b1;
            end
          end
        end
        StFail: begin
          // Parked until software or reset_n intervenes; lock is ignored.
        end
        default: begin
          state     <= StAssertRst;
          cnt       <= '0;
          pll_rst   <= 1'b1;
          sys_rst_n <= 1'b0;
          fail      <= 1'b0;
        end
      endcase
    end
  end

endmodule
